// File: rtl/tmds_multi_encoder.sv
// -----------------------------------------------------------------------------
// tmds_multi_encoder
//
// Multi-channel TMDS symbol encoder for DVI/HDMI links. Each channel turns one
// input sample per pixel clock into a 10-bit symbol. The period type is shared
// by all channels:
//   00 control      : 2-bit {c1,c0} -> fixed control token
//   01 video        : DVI 8b/10b with per-channel running disparity
//   10 data island  : TERC4 nibble code (control token when TERC4_EN == 0)
//   11 guard band   : fixed guard token, alternating with channel index
//
// Three register stages: input capture, transition-minimised q_m, then the
// DC-balanced output symbol. Every sample reaches dout three cycles after it
// is presented. Mode and side-band fields travel alongside the video data, so
// period changes cost no bubbles.
//
// Ports
//   clkin    in   1          pixel clock, rising edge
//   rstin_n  in   1          synchronous active-low reset
//   mode     in   2          period type, shared by all channels
//   din      in   8*NUM_CH   video byte, channel k at [8k+7:8k]
//   ctl      in   2*NUM_CH   {c1,c0}, channel k at [2k+1:2k]
//   aux      in   4*NUM_CH   TERC4 nibble, channel k at [4k+3:4k]
//   dout     out  10*NUM_CH  registered symbol, channel k at [10k+9:10k]
//   disp     out  5*NUM_CH   running disparity after the symbol on dout
// -----------------------------------------------------------------------------
module tmds_multi_encoder #(
    parameter int NUM_CH   = 3,
    parameter bit TERC4_EN = 1'b1
) (
    input  logic                   clkin,
    input  logic                   rstin_n,
    input  logic [1:0]             mode,
    input  logic [8*NUM_CH-1:0]    din,
    input  logic [2*NUM_CH-1:0]    ctl,
    input  logic [4*NUM_CH-1:0]    aux,
    output logic [10*NUM_CH-1:0]   dout,
    output logic [5*NUM_CH-1:0]    disp
);

    typedef enum logic [1:0] {
        MODE_CTL   = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_DATA  = 2'b10,
        MODE_GUARD = 2'b11
    } mode_t;

    function automatic logic [9:0] ctl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_symbol(input logic [3:0] x);
        logic [9:0] s;
        case (x)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Shared period type, delayed in step with the per-channel data.
    mode_t mode_a;
    mode_t mode_b;

    // NOTE: sequential state uses non-blocking assignments; reset is sampled
    // on the clock edge, so it lives inside the clocked branch.
    always_ff @(posedge clkin) begin
        if (!rstin_n) begin
            mode_a <= MODE_CTL;
            mode_b <= MODE_CTL;
        end else begin
            mode_a <= mode_t'(mode);
            mode_b <= mode_a;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [9:0] GUARD_SYM = (k % 2 == 0) ? 10'b1011001100
                                                         : 10'b0100110011;

        logic [7:0] din_a;
        logic [3:0] aux_a, aux_b;
        logic [1:0] ctl_a, ctl_b;
        logic [8:0] qm, qm_b;
        logic [4:0] bal, bal_b;        // N1(q_m[7:0]) - N0, two's complement
        logic [3:0] n1_din, n1_qm;
        logic       use_xnor, chain;
        logic [9:0] sym_nxt, sym_q;
        logic [4:0] cnt_nxt, cnt_q;

        // NOTE: pure datapath registers carry no reset; whatever they hold is
        // ignored because the reset-loaded mode selects a control token.
        always_ff @(posedge clkin) begin
            din_a <= din[8*k +: 8];
            aux_a <= aux[4*k +: 4];
            aux_b <= aux_a;
            qm_b  <= qm;
            bal_b <= bal;
        end

        always_ff @(posedge clkin) begin
            if (!rstin_n) begin
                ctl_a <= '0;
                ctl_b <= '0;
            end else begin
                ctl_a <= ctl[2*k +: 2];
                ctl_b <= ctl_a;
            end
        end

        // Stage 1: transition minimisation. The balance of q_m is computed
        // here so stage 2 only has a compare and a 5-bit add in its path.
        // NOTE: every variable gets a value before any branch, so no latch.
        always_comb begin
            n1_din = '0;
            for (int i = 0; i < 8; i++) n1_din = n1_din + {3'b000, din_a[i]};
            use_xnor = (n1_din > 4'd4) || ((n1_din == 4'd4) && !din_a[0]);
            qm    = '0;
            chain = din_a[0];
            qm[0] = chain;
            for (int i = 1; i < 8; i++) begin
                chain = use_xnor ? ~(chain ^ din_a[i]) : (chain ^ din_a[i]);
                qm[i] = chain;
            end
            qm[8] = ~use_xnor;
            n1_qm = '0;
            for (int i = 0; i < 8; i++) n1_qm = n1_qm + {3'b000, qm[i]};
            bal = {n1_qm, 1'b0} - 5'd8;
        end

        // Stage 2: DC balancing for video; fixed tokens otherwise, which
        // also restart the disparity count from zero.
        always_comb begin
            sym_nxt = ctl_symbol(ctl_b);
            cnt_nxt = '0;
            case (mode_b)
                MODE_VIDEO: begin
                    if (cnt_q == 5'd0 || bal_b == 5'd0) begin
                        sym_nxt = {~qm_b[8], qm_b[8],
                                   qm_b[8] ? qm_b[7:0] : ~qm_b[7:0]};
                        cnt_nxt = qm_b[8] ? cnt_q + bal_b : cnt_q - bal_b;
                    end else if (cnt_q[4] == bal_b[4]) begin
                        // Both nonzero here, so equal signs mean the symbol
                        // would push disparity further the same way: invert.
                        sym_nxt = {1'b1, qm_b[8], ~qm_b[7:0]};
                        cnt_nxt = cnt_q + {3'b000, qm_b[8], 1'b0} - bal_b;
                    end else begin
                        sym_nxt = {1'b0, qm_b[8], qm_b[7:0]};
                        cnt_nxt = cnt_q + bal_b - {3'b000, ~qm_b[8], 1'b0};
                    end
                end
                MODE_DATA: begin
                    if (TERC4_EN) sym_nxt = terc4_symbol(aux_b);
                end
                MODE_GUARD: sym_nxt = GUARD_SYM;
                default: ;
            endcase
        end

        always_ff @(posedge clkin) begin
            if (!rstin_n) begin
                sym_q <= '0;
                cnt_q <= '0;
            end else begin
                sym_q <= sym_nxt;
                cnt_q <= cnt_nxt;
            end
        end

        assign dout[10*k +: 10] = sym_q;
        assign disp[5*k +: 5]   = cnt_q;
    end

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_multi_encoder
//
// Three encoder instances share one stimulus bus:
//   u_dut3 : NUM_CH=3, TERC4 enabled
//   u_dut1 : NUM_CH=1, TERC4 enabled
//   u_dut4 : NUM_CH=4, TERC4 disabled (data-island mode falls back to control)
// A directed section checks hand-computed symbols; a mixed random stream with
// mid-stream resets is then scored against a bit-exact reference model.
// -----------------------------------------------------------------------------
module tb_tmds_multi_encoder;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] T0  = 10'b1010011100;
    localparam logic [9:0] TF  = 10'b1011000011;
    localparam logic [9:0] G0  = 10'b1011001100;
    localparam logic [9:0] G1  = 10'b0100110011;
    localparam logic [9:0] V00A = 10'b0100000000;
    localparam logic [9:0] V00B = 10'b1111111111;
    localparam logic [9:0] VFF  = 10'b1000000000;
    localparam logic [4:0] DM8 = 5'b11000;
    localparam logic [4:0] DP2 = 5'b00010;

    localparam logic [9:0] CTL_TAB [4] = '{C00, C01, C10, C11};
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    logic        clkin = 1'b0;
    logic        rstin_n;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [7:0]  ctl;
    logic [15:0] aux;
    logic [29:0] dout3;
    logic [14:0] disp3;
    logic [9:0]  dout1;
    logic [4:0]  disp1;
    logic [39:0] dout4;
    logic [19:0] disp4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [29:0] d3;
        logic [14:0] p3;
        logic [9:0]  d1;
        logic [4:0]  p1;
        logic [39:0] d4;
        logic [19:0] p4;
    } exp_t;

    exp_t exp_q[$];
    int   cnt3[3];
    int   cnt1;
    int   cnt4[4];

    always #5 clkin = ~clkin;

    tmds_multi_encoder #(.NUM_CH(3), .TERC4_EN(1'b1)) u_dut3 (
        .clkin(clkin), .rstin_n(rstin_n), .mode(mode),
        .din(din[23:0]), .ctl(ctl[5:0]), .aux(aux[11:0]),
        .dout(dout3), .disp(disp3));

    tmds_multi_encoder #(.NUM_CH(1), .TERC4_EN(1'b1)) u_dut1 (
        .clkin(clkin), .rstin_n(rstin_n), .mode(mode),
        .din(din[7:0]), .ctl(ctl[1:0]), .aux(aux[3:0]),
        .dout(dout1), .disp(disp1));

    tmds_multi_encoder #(.NUM_CH(4), .TERC4_EN(1'b0)) u_dut4 (
        .clkin(clkin), .rstin_n(rstin_n), .mode(mode),
        .din(din), .ctl(ctl), .aux(aux),
        .dout(dout4), .disp(disp4));

    task automatic check(input string tag, input logic [39:0] obs,
                         input logic [39:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [31:0] d,
                         input logic [7:0] c, input logic [15:0] a);
        mode = m;
        din  = d;
        ctl  = c;
        aux  = a;
    endtask

    task automatic check_all(input string tag,
                             input logic [29:0] e_d3, input logic [14:0] e_p3,
                             input logic [9:0]  e_d1, input logic [4:0]  e_p1,
                             input logic [39:0] e_d4, input logic [19:0] e_p4);
        check({tag, "_dout3"}, dout3, e_d3);
        check({tag, "_disp3"}, disp3, e_p3);
        check({tag, "_dout1"}, dout1, e_d1);
        check({tag, "_disp1"}, disp1, e_p1);
        check({tag, "_dout4"}, dout4, e_d4);
        check({tag, "_disp4"}, disp4, e_p4);
    endtask

    // Reference encoder for one channel, written from the algorithm text
    // using plain integer disparity arithmetic wrapped to 5 bits.
    function automatic logic [9:0] model_sym(
        input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
        input logic [3:0] a, input int ch, input bit terc4,
        input int cnt_in, output int cnt_out);
        logic [9:0] s;
        logic [8:0] q;
        int n1, ones, zeros, cnt;
        bit xn;
        cnt_out = 0;
        if (m == 2'b01) begin
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(d[i]);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            q[0] = d[0];
            for (int i = 1; i < 8; i++)
                q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
            q[8] = xn ? 1'b0 : 1'b1;
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(q[i]);
            zeros = 8 - ones;
            cnt = cnt_in;
            if (cnt == 0 || ones == zeros) begin
                if (q[8]) begin
                    s = {2'b01, q[7:0]};
                    cnt += ones - zeros;
                end else begin
                    s = {2'b10, ~q[7:0]};
                    cnt += zeros - ones;
                end
            end else if ((cnt > 0 && ones > zeros) || (cnt < 0 && zeros > ones)) begin
                s = {1'b1, q[8], ~q[7:0]};
                cnt += (q[8] ? 2 : 0) + zeros - ones;
            end else begin
                s = {1'b0, q[8], q[7:0]};
                cnt += ones - zeros - (q[8] ? 0 : 2);
            end
            cnt = cnt & 31;
            if (cnt > 15) cnt -= 32;
            cnt_out = cnt;
        end else if (m == 2'b11) begin
            s = (ch % 2 == 0) ? G0 : G1;
        end else if (m == 2'b10 && terc4) begin
            s = TERC4_TAB[a];
        end else begin
            s = CTL_TAB[c];
        end
        return s;
    endfunction

    task automatic sb_reset();
        exp_t e;
        rstin_n = 1'b0;
        drive(2'b01, $urandom, 8'($urandom), 16'($urandom));
        tick();
        check_all("sb_rst", '0, '0, '0, '0, '0, '0);
        rstin_n = 1'b1;
        exp_q.delete();
        e = '0;
        e.d3 = {3{C00}};
        e.d1 = C00;
        e.d4 = {4{C00}};
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int k = 0; k < 3; k++) cnt3[k] = 0;
        for (int k = 0; k < 4; k++) cnt4[k] = 0;
        cnt1 = 0;
    endtask

    task automatic sb_step(input logic [1:0] m, input logic [31:0] d,
                           input logic [7:0] c, input logic [15:0] a);
        exp_t e;
        int   nc;
        e = '0;
        drive(m, d, c, a);
        for (int k = 0; k < 3; k++) begin
            e.d3[10*k +: 10] = model_sym(m, d[8*k +: 8], c[2*k +: 2],
                                         a[4*k +: 4], k, 1'b1, cnt3[k], nc);
            cnt3[k] = nc;
            e.p3[5*k +: 5] = 5'(nc);
        end
        e.d1 = model_sym(m, d[7:0], c[1:0], a[3:0], 0, 1'b1, cnt1, nc);
        cnt1 = nc;
        e.p1 = 5'(nc);
        for (int k = 0; k < 4; k++) begin
            e.d4[10*k +: 10] = model_sym(m, d[8*k +: 8], c[2*k +: 2],
                                         a[4*k +: 4], k, 1'b0, cnt4[k], nc);
            cnt4[k] = nc;
            e.p4[5*k +: 5] = 5'(nc);
        end
        exp_q.push_back(e);
        tick();
        e = exp_q.pop_front();
        check_all("sb", e.d3, e.p3, e.d1, e.p1, e.d4, e.p4);
    endtask

    function automatic logic [1:0] pick_mode();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 6) return 2'b00;
        if (r == 7) return 2'b10;
        if (r == 8) return 2'b11;
        return 2'b01;
    endfunction

    initial begin
        // Reset held for two edges.
        rstin_n = 1'b0;
        drive(2'b00, '0, '0, '0);
        tick();
        tick();
        check_all("reset", '0, '0, '0, '0, '0, '0);

        // I1: control, a different {c1,c0} on each channel.
        rstin_n = 1'b1;
        drive(2'b00, '0, 8'b11_10_01_00, '0);
        tick();
        check_all("post_rst1", {3{C00}}, '0, C00, '0, {4{C00}}, '0);
        // I2: video 0x00.
        drive(2'b01, 32'h0000_0000, '0, '0);
        tick();
        check_all("post_rst2", {3{C00}}, '0, C00, '0, {4{C00}}, '0);
        // I3: video 0x00 again.
        drive(2'b01, 32'h0000_0000, '0, '0);
        tick();
        check_all("ctl_tokens", {C10, C01, C00}, '0, C00, '0,
                  {C11, C10, C01, C00}, '0);
        // I4: data island, nibbles 0/F/0/F.
        drive(2'b10, '0, '0, 16'hF0F0);
        tick();
        check_all("vid00_a", {3{V00A}}, {3{DM8}}, V00A, DM8, {4{V00A}}, {4{DM8}});
        // I5: data island, nibbles F/0/F/0.
        drive(2'b10, '0, '0, 16'h0F0F);
        tick();
        check_all("vid00_b", {3{V00B}}, {3{DP2}}, V00B, DP2, {4{V00B}}, {4{DP2}});
        // I6: video 0xFF, disparity already cleared by the data island.
        drive(2'b01, 32'hFFFF_FFFF, '0, '0);
        tick();
        check_all("terc4_a", {T0, TF, T0}, '0, T0, '0, {4{C00}}, '0);
        // I7: guard band. I6 was captured on the last edge and must not show yet.
        drive(2'b11, '0, '0, '0);
        tick();
        check_all("terc4_b", {TF, T0, TF}, '0, TF, '0, {4{C00}}, '0);
        // I8: video 0x00 straight after the guard band.
        drive(2'b01, 32'h0000_0000, '0, '0);
        tick();
        check_all("vidff_lat3", {3{VFF}}, {3{DM8}}, VFF, DM8, {4{VFF}}, {4{DM8}});
        // I9, I10: video that the following reset must discard.
        drive(2'b01, 32'hFFFF_FFFF, '0, '0);
        tick();
        check_all("guard", {G0, G1, G0}, '0, G0, '0, {G1, G0, G1, G0}, '0);
        drive(2'b01, 32'hA5C3_0F81, '0, '0);
        tick();
        check_all("vid_after_guard", {3{V00A}}, {3{DM8}}, V00A, DM8,
                  {4{V00A}}, {4{DM8}});

        // Random mixed-mode stream, one-cycle reset mid-stream, then a
        // fresh video-only stream and another mid-stream reset.
        sb_reset();
        for (int n = 0; n < 40; n++)
            sb_step(pick_mode(), $urandom, 8'($urandom), 16'($urandom));
        sb_reset();
        for (int n = 0; n < 40; n++)
            sb_step(2'b01, $urandom, 8'($urandom), 16'($urandom));
        sb_reset();
        // Boundary bytes: N1 == 4 with bit 0 clear and set, extremes.
        sb_step(2'b01, 32'h1E1E_1E1E, '0, '0);
        sb_step(2'b01, 32'h0F0F_0F0F, '0, '0);
        sb_step(2'b01, 32'h0000_00FF, '0, '0);
        sb_step(2'b01, 32'hFF00_FF00, '0, '0);
        for (int n = 0; n < 12; n++)
            sb_step(pick_mode(), $urandom, 8'($urandom), 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
